// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN lets trivial operations (divide by zero, signed overflow, zero multiply) skip RUN.
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      op, op_next;
  logic            neg, neg_next;
  logic [XLEN-1:0] a_reg, a_next;
  logic [XLEN-1:0] hi, hi_next;
  logic [XLEN-1:0] lo, lo_next;
  logic [XLEN-1:0] result_next;

  // Operand decode at latch time
  logic            s1_signed, s2_signed, neg1, neg2, rs2_zero, neg_in;
  logic [XLEN-1:0] mag1, mag2;

  assign s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg1      = s1_signed && rs1_data[XLEN-1];
  assign neg2      = s2_signed && rs2_data[XLEN-1];
  assign mag1      = neg1 ? -rs1_data : rs1_data;
  assign mag2      = neg2 ? -rs2_data : rs2_data;
  assign rs2_zero  = (rs2_data == '0);

  // Quotient keeps the all-ones divide-by-zero answer unsigned; remainder follows the dividend
  always_comb begin
    if (!funct3[2])     neg_in = neg1 ^ neg2;
    else if (funct3[1]) neg_in = neg1;
    else                neg_in = (neg1 ^ neg2) && !rs2_zero;
  end

  logic            early;
  logic [XLEN-1:0] early_val;

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early     = 1'b0;
    early_val = '0;
    if (funct3[2]) begin
      if (rs2_zero) begin
        early     = 1'b1;
        early_val = funct3[1] ? rs1_data : '1;
      end else if (!funct3[0] && rs1_data == MIN_NEG && rs2_data == '1) begin
        early     = 1'b1;
        early_val = funct3[1] ? '0 : MIN_NEG;
      end
    end else if (rs1_data == '0 || rs2_data == '0) begin
      early     = 1'b1;
      early_val = '0;
    end
  end
`else
  assign early     = 1'b0;
  assign early_val = '0;
`endif

  // One iteration: multiply uses {hi,lo} as a right-shifting product, divide as a left-shifting {rem,quot}
  logic [XLEN:0]     mul_sum, shifted, diff;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   div_val, div_s, fin;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
  assign shifted = {hi, lo[XLEN-1]};
  assign diff    = shifted - {1'b0, a_reg};

  always_comb begin
    if (op[2]) begin
      step_hi = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  assign prod    = {step_hi, step_lo};
  assign prod_s  = neg ? -prod : prod;
  assign div_val = op[1] ? step_hi : step_lo;
  assign div_s   = neg ? -div_val : div_val;

  always_comb begin
    case (op)
      3'b000:                 fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
      default:                fin = div_s;
    endcase
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    op_next     = op;
    neg_next    = neg;
    a_next      = a_reg;
    hi_next     = hi;
    lo_next     = lo;
    result_next = result;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_next  = funct3;
            neg_next = neg_in;
            a_next   = mag2;
            hi_next  = '0;
            lo_next  = mag1;
            cnt_next = '0;
            if (early) begin
              state_next  = DONE;
              result_next = early_val;
            end else begin
              state_next = RUN;
            end
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          hi_next  = step_hi;
          lo_next  = step_lo;
          cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
          if (cnt == LAST) begin
            state_next  = DONE;
            result_next = fin;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      neg    <= 1'b0;
      a_reg  <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      op     <= op_next;
      neg    <= neg_next;
      a_reg  <= a_next;
      hi     <= hi_next;
      lo     <= lo_next;
      result <= result_next;
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = (start && (state == IDLE || state == DONE) && !flush) || busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic reference model checked every cycle plus directed literal vectors.
module tb_muldiv_seq;

  localparam logic [31:0] MIN_NEG = 32'h8000_0000;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (f)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) return (b == 0) || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Timing model: an accepted op occupies 32 RUN cycles, then one done cycle
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    <= 0;
      m_done   <= 1'b0;
      m_result <= '0;
    end else if (flush) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done   <= 1'b1;
        m_result <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
    end else if (start) begin
      if (EARLY && is_early(funct3, rs1_data, rs2_data)) begin
        m_done   <= 1'b1;
        m_result <= ref_op(funct3, rs1_data, rs2_data);
      end else begin
        m_pend <= ref_op(funct3, rs1_data, rs2_data);
        m_cnt  <= 32;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_cnt != 0});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_stall", {31'b0, stall}, {31'b0, (start && m_cnt == 0 && !flush) || m_cnt != 0});
      chk("cyc_result", result, m_result);
    end
  end

  // Called at posedge+2; start is sampled on the next edge
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    int lat;
    lat = (EARLY && is_early(f, a, b)) ? 1 : 33;
    start = 1'b1; funct3 = f; rs1_data = a; rs2_data = b;
    @(posedge clk); #2;
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    $display("[TB] %s f=%0d rs1=%h rs2=%h -> result=%h after %0d cycles", name, f, a, b, result, n);
    chk({name, "_res"}, result, exp);
    chk({name, "_lat"}, n, lat);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  vec_t vecs [0:15] = '{
    '{"mul_7_m3",      3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{"mulhu_ff",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{"mulh_ff",       3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
    '{"div_m20_3",     3'd4, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA},
    '{"rem_m20_3",     3'd6, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE},
    '{"divu_by0",      3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF},
    '{"rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{"div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{"mulhsu_m2_3",   3'd2, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF},
    '{"div_m5_by0",    3'd4, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF},
    '{"remu_by0",      3'd7, 32'd5,        32'd0,        32'd5},
    '{"mul_zero",      3'd0, 32'd0,        32'd12345,    32'd0},
    '{"mulh_min_min",  3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
    '{"divu_big_2",    3'd5, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF},
    '{"remu_big_10",   3'd7, 32'hFFFF_FFFF, 32'd10,       32'd5},
    '{"rem_m20_by0",   3'd6, 32'hFFFF_FFEC, 32'd0,        32'hFFFF_FFEC}
  };

  initial begin
    int n;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // First op straight after reset release, then the directed table
    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r);

    // Flush at RUN cycle 10 with a competing start
    run_op("pre_flush", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd5;
    @(posedge clk); #2;
    start = 1'b0;
    n = 1;
    while (n < 10) begin @(posedge clk); #2; n++; end
    flush = 1'b1; start = 1'b1; funct3 = 3'd5; rs1_data = 32'd9; rs2_data = 32'd2;
    @(posedge clk); #2;
    $display("[TB] flush at RUN cycle 10 -> busy=%0b done=%0b result=%h", busy, done, result);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_done", {31'b0, done}, 32'd0);
    chk("flush_result", result, 32'hFFFF_FFFE);
    flush = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    #2 chk("flush_hold", result, 32'hFFFF_FFFE);

    // Back-to-back with start held; operands changed during RUN must be ignored until DONE
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'hFFFF_FFFD;
    @(posedge clk); #2;
    funct3 = 3'd5; rs1_data = 32'd100; rs2_data = 32'd7;
    n = 1;
    while (!done && n < 200) begin @(posedge clk); #2; n++; end
    $display("[TB] b2b first -> result=%h after %0d cycles", result, n);
    chk("b2b_first_res", result, 32'hFFFF_FFEB);
    chk("b2b_first_lat", n, 33);
    @(posedge clk); #2;
    chk("b2b_no_gap", {31'b0, busy}, 32'd1);
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin @(posedge clk); #2; n++; end
    $display("[TB] b2b second -> result=%h after %0d cycles", result, n);
    chk("b2b_second_res", result, 32'd14);
    chk("b2b_second_lat", n, 33);

    // Asynchronous reset at RUN cycle 5
    start = 1'b1; funct3 = 3'd0; rs1_data = 32'd7; rs2_data = 32'd9;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    $display("[TB] reset at RUN cycle 5 -> busy=%0b done=%0b stall=%0b result=%h", busy, done, stall, result);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_result", result, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_op("post_reset", 3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
